// File: rtl/tdm4_demux.sv
// tdm4_demux: recovers four W-bit channel words from a serial TDM line.
// The frame is located with frame_sync. Each slot is received MSB first.
// A complete frame is published to y0..y3 in one step, together with a
// single-cycle frame_valid pulse.
module tdm4_demux #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  input  logic         frame_sync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [1:0]   slot
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] BIT_LAST = CW'(W - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  bit_cnt_r;
  logic [1:0]     slot_r;
  logic [1:0]     miss_r;
  logic [W-1:0]   shift_r;
  logic [W-1:0]   stage_r [0:3];
  logic [W-1:0]   y0_r;
  logic [W-1:0]   y1_r;
  logic [W-1:0]   y2_r;
  logic [W-1:0]   y3_r;
  logic           frame_valid_r;
  logic           sync_err_r;
  logic           locked_r;

  logic [W-1:0]   shifted_s;
  logic [W-1:0]   first_bit_s;
  logic           frame_start_s;

  // Decode the next shift value, a fresh frame's first bit, and frame-start position
  always_comb begin
    shifted_s     = {shift_r[W-2:0], din};
    first_bit_s   = {{(W-1){1'b0}}, din};
    frame_start_s = 1'b0;
    if ((bit_cnt_r == '0) && (slot_r == 2'd0)) begin
      frame_start_s = 1'b1;
    end else begin
      frame_start_s = 1'b0;
    end
  end

  // Framing FSM, deserializer, staging and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= HUNT;
      bit_cnt_r     <= '0;
      slot_r        <= 2'd0;
      miss_r        <= 2'd0;
      shift_r       <= '0;
      for (int k = 0; k < 4; k++) begin
        stage_r[k] <= '0;
      end
      y0_r          <= '0;
      y1_r          <= '0;
      y2_r          <= '0;
      y3_r          <= '0;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      // Pulses default low; disabled cycles hold all other state.
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      if (en) begin
        case (state_r)
          HUNT: begin
            if (frame_sync) begin
              // This bit is the MSB of slot 0.
              state_r   <= LOCKED;
              locked_r  <= 1'b1;
              shift_r   <= first_bit_s;
              bit_cnt_r <= CW'(1);
              slot_r    <= 2'd0;
              miss_r    <= 2'd0;
            end
          end
          LOCKED: begin
            if (frame_sync && !frame_start_s) begin
              // Misplaced sync: drop the partial frame and restart on this bit.
              sync_err_r <= 1'b1;
              shift_r    <= first_bit_s;
              bit_cnt_r  <= CW'(1);
              slot_r     <= 2'd0;
              miss_r     <= 2'd0;
            end else if (!frame_sync && frame_start_s && (miss_r == 2'd1)) begin
              // Second missed sync in a row: give up the lock, keep y as is.
              state_r   <= HUNT;
              locked_r  <= 1'b0;
              bit_cnt_r <= '0;
              slot_r    <= 2'd0;
              miss_r    <= 2'd0;
              shift_r   <= '0;
            end else begin
              if (frame_start_s) begin
                if (frame_sync) begin
                  miss_r <= 2'd0;
                end else begin
                  miss_r <= miss_r + 2'd1;
                end
              end
              shift_r <= shifted_s;
              if (bit_cnt_r == BIT_LAST) begin
                bit_cnt_r       <= '0;
                stage_r[slot_r] <= shifted_s;
                slot_r          <= slot_r + 2'd1;
                if (slot_r == 2'd3) begin
                  // Whole frame is known: publish all four words together.
                  y0_r          <= stage_r[0];
                  y1_r          <= stage_r[1];
                  y2_r          <= stage_r[2];
                  y3_r          <= shifted_s;
                  frame_valid_r <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + CW'(1);
              end
            end
          end
          default: begin
            state_r   <= HUNT;
            locked_r  <= 1'b0;
            bit_cnt_r <= '0;
            slot_r    <= 2'd0;
            miss_r    <= 2'd0;
          end
        endcase
      end
    end
  end

  assign y0          = y0_r;
  assign y1          = y1_r;
  assign y2          = y2_r;
  assign y3          = y3_r;
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;
  assign locked      = locked_r;
  assign slot        = slot_r;

endmodule

// File: tb/tb_tdm4_demux.sv
// tb_tdm4_demux: directed scenarios plus randomized traffic for tdm4_demux (W=8).
// The reference model tracks the position within the frame as a plain integer.
// It stores the received frame as a bit array and builds words arithmetically.
module tb_tdm4_demux;

  localparam int W  = 8;
  localparam int FB = 4 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         din;
  logic         frame_sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid;
  logic         locked;
  logic         sync_err;
  logic [1:0]   slot;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit           m_locked;
  int           m_pos;
  int           m_miss;
  bit           m_bits [0:FB-1];
  logic [W-1:0] m_y [0:3];
  bit           m_fv;
  bit           m_se;

  tdm4_demux #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .frame_sync  (frame_sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .slot        (slot)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_word(input int s);
    int w;
    w = 0;
    for (int b = 0; b < W; b++) begin
      w = w * 2 + int'(m_bits[s * W + b]);
    end
    return W'(w);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit f, input bit d);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_pos    = 0;
      m_miss   = 0;
      for (int k = 0; k < 4; k++) m_y[k] = '0;
    end else if (e) begin
      if (!m_locked) begin
        if (f) begin
          m_locked  = 1'b1;
          m_bits[0] = d;
          m_pos     = 1;
          m_miss    = 0;
        end
      end else if (f && m_pos != 0) begin
        m_se      = 1'b1;
        m_bits[0] = d;
        m_pos     = 1;
        m_miss    = 0;
      end else if (!f && m_pos == 0 && m_miss == 1) begin
        m_locked = 1'b0;
        m_pos    = 0;
        m_miss   = 0;
      end else begin
        if (m_pos == 0) m_miss = f ? 0 : m_miss + 1;
        m_bits[m_pos] = d;
        m_pos++;
        if (m_pos == FB) begin
          m_pos = 0;
          for (int k = 0; k < 4; k++) m_y[k] = model_word(k);
          m_fv = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit f, input bit d);
    rst        = r;
    en         = e;
    frame_sync = f;
    din        = d;
    @(posedge clk);
    model_step(r, e, f, d);
    @(negedge clk);
    check_val("y0", 32'(y0), 32'(m_y[0]));
    check_val("y1", 32'(y1), 32'(m_y[1]));
    check_val("y2", 32'(y2), 32'(m_y[2]));
    check_val("y3", 32'(y3), 32'(m_y[3]));
    check_val("frame_valid", 32'(frame_valid), 32'(m_fv));
    check_val("sync_err", 32'(sync_err), 32'(m_se));
    check_val("locked", 32'(locked), 32'(m_locked));
    check_val("slot", 32'(slot), 32'(m_pos / W));
  endtask

  // Send frame bits lo..hi; optional sync on bit lo; optional idle cycle after each bit
  task automatic send_range(input logic [31:0] data, input int lo, input int hi,
                            input bit sync_lo, input bit toggle);
    logic [31:0] v;
    v = data;
    for (int i = lo; i <= hi; i++) begin
      step(1'b0, 1'b1, sync_lo && (i == lo), v[31 - i]);
      if (toggle) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int  fv_cycles;
    bit  r, e, f;
    rst = 1'b1; en = 1'b0; din = 1'b0; frame_sync = 1'b0;
    m_locked = 1'b0; m_pos = 0; m_miss = 0;
    for (int k = 0; k < 4; k++) m_y[k] = '0;
    for (int k = 0; k < FB; k++) m_bits[k] = 1'b0;

    // Reset state, with junk on the inputs
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_val("rst_locked", 32'(locked), 32'h0);

    // Bits without frame_sync are ignored in HUNT
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("hunt_slot", 32'(slot), 32'h0);

    // Basic frame
    send_range(32'hA53C0FF0, 0, 31, 1'b1, 1'b0);
    check_val("basic_y0", 32'(y0), 32'hA5);
    check_val("basic_y3", 32'(y3), 32'hF0);
    check_val("basic_fv", 32'(frame_valid), 32'h1);
    check_val("basic_lock", 32'(locked), 32'h1);

    // Same frame with en toggling
    fv_cycles = 0;
    send_range(32'hA53C0FF0, 0, 30, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("toggle_fv", 32'(frame_valid), 32'h1);
    check_val("toggle_y1", 32'(y1), 32'h3C);

    // Misplaced sync at slot 2, bit 3, then a clean frame
    send_range(32'hDEADBEEF, 0, 18, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("mis_sync_err", 32'(sync_err), 32'h1);
    check_val("mis_y_hold", 32'(y2), 32'h0F);
    send_range(32'h11223344, 1, 31, 1'b0, 1'b0);
    check_val("after_err_y0", 32'(y0), 32'h11);
    check_val("after_err_y3", 32'(y3), 32'h44);

    // Missed syncs: one miss is tolerated, the second loses lock
    send_range(32'h5566AA99, 0, 31, 1'b0, 1'b0);
    check_val("miss1_y0", 32'(y0), 32'h55);
    check_val("miss1_lock", 32'(locked), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("miss2_lock", 32'(locked), 32'h0);
    check_val("miss2_y3", 32'(y3), 32'h99);

    // Reset at slot 1, bit 4
    send_range(32'h12345678, 0, 11, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_val("midrst_y0", 32'(y0), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    send_range(32'hC3A55A3C, 0, 31, 1'b1, 1'b0);
    check_val("postrst_y2", 32'(y2), 32'h5A);

    // Back-to-back synced frames
    for (int n = 0; n < 3; n++) begin
      send_range($urandom, 0, 31, 1'b1, 1'b0);
      check_val("b2b_fv", 32'(frame_valid), 32'h1);
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 3) != 0);
      if (m_pos == 0) f = ($urandom_range(0, 9) < 7);
      else            f = ($urandom_range(0, 59) == 0);
      step(r, e, f, 1'($urandom_range(0, 1)));
      if (m_fv) fv_cycles++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdm4_demux.md
TDM4_DEMUX -- requirements
Module: tdm4_demux

Interface
REQ-001 Parameter: W, default 8, bits per channel slot (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: en  input  1  bit-enable; din and frame_sync are sampled only on cycles with en=1.
REQ-005 Port: din  input  1  serial TDM line carrying 4 slots of W bits, slot 0 first, each slot MSB first.
REQ-006 Port: frame_sync  input  1  marks the first bit (slot 0, MSB) of a frame when high with en=1.
REQ-007 Port: y0,y1,y2,y3  output  W each  registered channel words for slots 0..3.
REQ-008 Port: frame_valid  output  1  one-cycle pulse when y0..y3 update.
REQ-009 Port: locked  output  1  high while the FSM is in LOCKED.
REQ-010 Port: sync_err  output  1  one-cycle pulse on a misplaced frame_sync.
REQ-011 Port: slot  output  2  index of the slot currently being received (0 in HUNT).

Function
REQ-012 FSM states: HUNT and LOCKED only; reset state is HUNT.
REQ-013 HUNT: din ignored until a cycle with en=1 and frame_sync=1. That cycle's din becomes bit 0 of slot 0; bit counter becomes 1; slot stays 0; FSM goes to LOCKED.
REQ-014 LOCKED: each en=1 cycle shifts din into a W-bit shift register MSB first and increments the bit counter.
REQ-015 Bit counter wraps from W-1 to 0. On wrap, the completed word is written into a staging register for the current slot, and slot increments modulo 4.
REQ-016 Completion of slot 3 copies all four staging words into y0..y3 on the same edge and asserts frame_valid for exactly one cycle after that edge. Outputs are never partially updated.
REQ-017 Latency: y0..y3 and frame_valid become visible in the clock cycle after the edge that samples the last bit of slot 3.
REQ-018 en=0 cycles: counters, shift register, slot and FSM hold; frame_valid and sync_err are 0.
REQ-019 frame_sync=1 with en=1 in LOCKED at slot 0, bit 0: accepted; no error.
REQ-020 frame_sync=1 with en=1 in LOCKED at any other position:
  - sync_err pulses for one cycle;
  - the partial frame is discarded and staging is not copied to y;
  - that cycle's din is taken as slot 0, bit 0, and the FSM stays LOCKED.
REQ-021 Frame start (slot 0, bit 0, en=1) in LOCKED without frame_sync: the frame is still decoded, and a 2-bit miss counter increments.
REQ-022 Any frame start with frame_sync clears the miss counter.
REQ-023 A second consecutive missed frame_sync returns the FSM to HUNT on that edge:
  - locked drops the following cycle;
  - counters clear;
  - y0..y3 hold their last values.
REQ-024 frame_sync coinciding with the completion of slot 3 on the previous enabled bit is the normal case: frame_valid for the old frame and acceptance of the new frame both occur, and no error is flagged.

Reset
REQ-025 rst=1 on any edge, including mid-frame, drives these values, and they hold while rst=1:
  - FSM=HUNT;
  - bit counter, slot, miss counter, shift and staging registers = 0;
  - y0..y3 = 0;
  - frame_valid = 0, sync_err = 0, locked = 0.
REQ-026 rst has priority over en, frame_sync and din. The first frame after reset requires frame_sync.

Verification
REQ-027 W=8, en=1 constant, frame_sync at bit 0, bits A5,3C,0F,F0 -> one cycle after the 32nd bit: y0=A5, y1=3C, y2=0F, y3=F0; frame_valid=1 for 1 cycle; locked=1.
REQ-028 Same frame with en toggling 1,0,1,0 -> identical y values; frame_valid arrives after 64 clocks; no sync_err.
REQ-029 frame_sync reasserted at slot 2, bit 3 -> sync_err=1 for 1 cycle; y unchanged; the next full frame 11,22,33,44 decodes correctly.
REQ-030 Two frames without frame_sync after lock -> first frame decoded with frame_valid; at the second frame start, locked drops; y retains the first frame's values.
REQ-031 rst asserted at slot 1, bit 4 -> all outputs 0 next cycle; din ignored until frame_sync; the subsequent frame decodes correctly.
REQ-032 Back-to-back frames with frame_sync every 32 bits -> frame_valid every 32 enabled cycles; sync_err never asserted.
